// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame types, parity codes and configuration helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int unsigned MIN_DATA_BITS = 5;

    // Out-of-range requests saturate rather than wrap so a bad register write still frames sanely.
    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
        if (req < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end
        if (req > max_bits) begin
            return max_bits;
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous restart, shareable by TX and RX
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_tick_o
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    // Tick on the last clk of a bit period; the counter reloads there, so div_i=0 ticks every clk.
    assign w_tick     = (r_cnt == div_i);
    assign bit_tick_o = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart_i || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with runtime baud divider and per-frame format
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the FSM (adds fifo_level_o).
module uart_tx_param #(
    parameter int DATA_W     = 9,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [3:0]        data_bits_i,
    input  logic [1:0]        parity_i,
    input  logic              stop2_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
`ifdef UART_TX_FIFO_EN
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
`endif
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              tx_o
);
    import uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_W);

    if (DATA_W < int'(MIN_DATA_BITS) || DATA_W > 9 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: unsupported DATA_W or FIFO_DEPTH");
    end

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic              r_init;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_nbits;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic              r_stop_idx;
    logic [BIT_W-1:0]  r_bit_idx;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_last_bit;
    logic              w_stop_end;
    logic              w_free;
    logic              w_take;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_payload;
    logic [3:0]        w_nbits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    assign w_last_bit = ((int'(r_bit_idx) + 1) == int'(r_nbits));
    assign w_stop_end = (r_state == ST_STOP) && w_tick && (!r_stop2 || r_stop_idx);
    // Opening the door on the final stop clk lets a pending word start with no idle gap.
    assign w_free     = r_init && ((r_state == ST_IDLE) || w_stop_end);

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign ready_o      = r_init && !w_full;
    assign w_push       = valid_i && ready_o;
    assign w_pop        = w_free && !w_empty;
    assign w_take       = w_pop;
    assign w_head       = r_mem[r_rd_ptr];
    assign fifo_level_o = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end
`else
    assign ready_o = w_free;
    assign w_take  = w_free && valid_i;
    assign w_head  = data_i;
`endif

    assign w_nbits = clamp_bits(data_bits_i, 4'(DATA_W));

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (i < int'(w_nbits));
        end
    end

    assign w_payload = w_head & w_mask;

    // Whole frame format is captured at frame start; later input changes wait for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_data    <= '0;
            r_nbits   <= 4'(MIN_DATA_BITS);
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else if (w_take) begin
            r_div     <= baud_div_i;
            r_data    <= w_payload;
            r_nbits   <= w_nbits;
            r_par_en  <= (parity_i == PAR_ODD) || (parity_i == PAR_EVEN);
            r_par_bit <= (parity_i == PAR_ODD) ? ~(^w_payload) : (^w_payload);
            r_stop2   <= stop2_i;
        end
    end

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_i  (w_take),
        .div_i      (r_div),
        .bit_tick_o (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && w_last_bit) begin
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_stop_end) begin
                    w_next = w_take ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            if (r_state != ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (r_state != ST_STOP) begin
                r_stop_idx <= 1'b0;
            end else if (w_tick) begin
                r_stop_idx <= ~r_stop_idx;
            end
        end
    end

    // Line outputs are registered from the current state, so the pin trails the FSM by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != ST_IDLE);
            r_done <= w_stop_end;
            case (r_state)
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= r_data[r_bit_idx];
                ST_PARITY: r_tx <= r_par_bit;
                default:   r_tx <= 1'b1;
            endcase
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed table-driven bench for uart_tx_param
module tb_uart_tx_param;

    localparam int DATA_W     = 9;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic [DIV_W-1:0]  baud_div_i  = '0;
    logic [3:0]        data_bits_i = 4'd8;
    logic [1:0]        parity_i    = 2'd0;
    logic              stop2_i     = 1'b0;
    logic [DATA_W-1:0] data_i      = '0;
    logic              valid_i     = 1'b0;
    logic              ready_o;
    logic              busy_o;
    logic              done_o;
    logic              tx_o;
`ifdef UART_TX_FIFO_EN
    logic [$clog2(FIFO_DEPTH):0] fifo_level_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] div;
        logic [3:0]  bits;
        logic [1:0]  par;
        logic        stop2;
        logic [8:0]  data;
        int          len;
        logic [63:0] frame;
    } vec_t;

    uart_tx_param #(
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div_i  (baud_div_i),
        .data_bits_i (data_bits_i),
        .parity_i    (parity_i),
        .stop2_i     (stop2_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
`ifdef UART_TX_FIFO_EN
        .fifo_level_o(fifo_level_o),
`endif
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tx_o        (tx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one word, wait for acceptance, then either scramble config or queue next_data.
    task automatic send(input string tag, input vec_t v, input logic keep, input logic [8:0] next_data);
        int guard;
        guard = 0;
        @(negedge clk);
        baud_div_i  = v.div;
        data_bits_i = v.bits;
        parity_i    = v.par;
        stop2_i     = v.stop2;
        data_i      = v.data;
        valid_i     = 1'b1;
        while (ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check1({tag, " accept_ready"}, ready_o, 1'b1);
        @(posedge clk);
        #1;
        if (keep) data_i = next_data;
        else valid_i = 1'b0;
        check1({tag, " latency_tx_high"}, tx_o, 1'b1);
        repeat (LAT) @(posedge clk);
        #1;
        if (!keep) begin
            baud_div_i  = '0;
            data_bits_i = 4'd5;
            parity_i    = 2'd1;
            stop2_i     = ~v.stop2;
            data_i      = ~v.data;
        end
    endtask

    // Sample the line once per clk at negedge; expected bit b occupies per consecutive clks.
    task automatic watch(input string tag, input logic [63:0] exp, input int len, input int per,
                         input int exp_done);
        int   dones;
        logic bad;
        logic mid;
        logic drop;
        logic last_done;
        dones = 0;
        bad = 1'b0;
        drop = 1'b0;
        last_done = 1'b0;
        for (int b = 0; b < len; b++) begin
            mid = 1'b1;
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                if (drop) begin
                    valid_i = 1'b0;
                    drop = 1'b0;
                end
                if (valid_i && ready_o) drop = 1'b1;
                if (tx_o !== exp[b] || busy_o !== 1'b1) bad = 1'b1;
                if (done_o === 1'b1) dones++;
                if (c == per / 2) mid = tx_o;
                last_done = done_o;
            end
            check1($sformatf("%s bit%0d", tag, b), mid, exp[b]);
        end
        valid_i = 1'b0;
        check1({tag, " steady_busy"}, bad, 1'b0);
        checkn({tag, " done_count"}, dones, exp_done);
        check1({tag, " done_on_last_clk"}, last_done, 1'b1);
        @(negedge clk);
        check1({tag, " idle_tx"}, tx_o, 1'b1);
        check1({tag, " idle_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        vec_t vecs [6];
        vec_t b2b;

        vecs[0] = '{div: 16'd3, bits: 4'd8,  par: 2'd0, stop2: 1'b0, data: 9'h055, len: 10, frame: 64'h2AA};
        vecs[1] = '{div: 16'd1, bits: 4'd7,  par: 2'd1, stop2: 1'b0, data: 9'h003, len: 10, frame: 64'h306};
        vecs[2] = '{div: 16'd2, bits: 4'd8,  par: 2'd2, stop2: 1'b0, data: 9'h0FF, len: 11, frame: 64'h5FE};
        vecs[3] = '{div: 16'd0, bits: 4'd3,  par: 2'd0, stop2: 1'b0, data: 9'h0FF, len: 7,  frame: 64'h07E};
        vecs[4] = '{div: 16'd1, bits: 4'd15, par: 2'd0, stop2: 1'b1, data: 9'h1A5, len: 12, frame: 64'hF4A};
        vecs[5] = '{div: 16'd0, bits: 4'd6,  par: 2'd3, stop2: 1'b0, data: 9'h1EA, len: 8,  frame: 64'h0D4};

        repeat (2) @(negedge clk);
        check1("reset tx", tx_o, 1'b1);
        check1("reset ready", ready_o, 1'b0);
        check1("reset busy", busy_o, 1'b0);
        check1("reset done", done_o, 1'b0);
        rst_n = 1'b1;
        #1;
        check1("ready before first clk", ready_o, 1'b0);
        @(negedge clk);
        check1("ready after first clk", ready_o, 1'b1);

        for (int i = 0; i < 6; i++) begin
            send($sformatf("vec%0d", i), vecs[i], 1'b0, 9'h000);
            watch($sformatf("vec%0d", i), vecs[i].frame, vecs[i].len, int'(vecs[i].div) + 1, 1);
        end

        // Two stop bits with valid held: second START follows the last stop clk directly.
        b2b = '{div: 16'd1, bits: 4'd8, par: 2'd0, stop2: 1'b1, data: 9'h05A, len: 22, frame: 64'h3C36B4};
        send("b2b", b2b, 1'b1, 9'h0C3);
        watch("b2b", b2b.frame, b2b.len, 2, 2);

        // Reset in the middle of a data bit that is driving the line low.
        begin
            vec_t z;
            z = '{div: 16'd3, bits: 4'd8, par: 2'd0, stop2: 1'b0, data: 9'h000, len: 10, frame: 64'h200};
            send("abort", z, 1'b0, 9'h000);
            repeat (6) @(negedge clk);
            check1("abort pre tx low", tx_o, 1'b0);
            check1("abort pre busy", busy_o, 1'b1);
            rst_n = 1'b0;
            #1;
            check1("abort tx high", tx_o, 1'b1);
            check1("abort busy low", busy_o, 1'b0);
            check1("abort ready low", ready_o, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            send("post_reset", vecs[0], 1'b0, 9'h000);
            watch("post_reset", vecs[0].frame, vecs[0].len, 4, 1);
        end

`ifdef UART_TX_FIFO_EN
        begin
            int   pushed;
            int   g;
            logic saw_full;
            pushed = 0;
            saw_full = 1'b0;
            @(negedge clk);
            baud_div_i  = '0;
            data_bits_i = 4'd8;
            parity_i    = 2'd0;
            stop2_i     = 1'b0;
            fork
                begin
                    g = 0;
                    while (pushed < 9 && g < 400) begin
                        data_i  = 9'(32'h30 + pushed);
                        valid_i = 1'b1;
                        if (fifo_level_o == 4'd8) begin
                            saw_full = 1'b1;
                            check1("fifo ready at full", ready_o, 1'b0);
                        end
                        if (ready_o) pushed++;
                        @(negedge clk);
                        g++;
                    end
                    valid_i = 1'b0;
                end
                begin
                    for (int w = 0; w < 9; w++) begin
                        logic [7:0] got;
                        int         g2;
                        g2 = 0;
                        @(negedge clk);
                        while (tx_o !== 1'b0 && g2 < 400) begin
                            @(negedge clk);
                            g2++;
                        end
                        for (int b = 0; b < 8; b++) begin
                            @(negedge clk);
                            got[b] = tx_o;
                        end
                        @(negedge clk);
                        checkn($sformatf("fifo word%0d", w), int'(got), 32'h30 + w);
                    end
                end
            join
            repeat (4) @(negedge clk);
            check1("fifo reached full", saw_full, 1'b1);
            checkn("fifo level drained", int'(fifo_level_o), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
